// File: rtl/output_port_arbiter_pkg.sv
// Shared router definitions: port count, flit width, port index names,
// flit type and the output arbiter state encoding.
package output_port_arbiter_pkg;
  localparam int PORTS = 5;
  localparam int PL    = 8;
  localparam int PTR_W = $clog2(PORTS);

  localparam int NORTH = 0;
  localparam int EAST  = 1;
  localparam int SOUTH = 2;
  localparam int WEST  = 3;
  localparam int LOCAL = 4;

  typedef logic [PL-1:0] flit_t;

  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the input queues, the output arbiter and the
// downstream link.
//   req_valid/req_data : queue heads (non-empty flag, head flit)
//   req_take           : per-queue pop strobe
//   out_data/out_valid : registered output slot; out_ready accepts it
//   grant_valid/id     : current grant status
// master = arbiter side, slave = queues + downstream side.
interface output_port_arbiter_if;
  import output_port_arbiter_pkg::*;

  logic [PORTS-1:0]             req_valid;
  flit_t [PORTS-1:0]            req_data;
  logic [PORTS-1:0]             req_take;
  flit_t                        out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         grant_valid;
  logic [PTR_W-1:0]             grant_id;

  modport master (
    input  req_valid, req_data, out_ready,
    output req_take, out_data, out_valid, grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_data, out_ready,
    input  req_take, out_data, out_valid, grant_valid, grant_id
  );
endinterface

// File: rtl/output_port_arbiter_rr_pick.sv
// Rotating-priority first-one finder (combinational).
//   req   : request vector, N bits
//   start : index with highest priority; search wraps modulo N
//   found : any request set
//   idx   : first set index at or after start (0 when none)
module output_port_arbiter_rr_pick #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(start) + i) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end
endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin output port arbiter: grants one input queue at a time and
// moves up to MAX_BURST flits from it into a registered output slot.
//   clk, rst_n : clock, async active-low reset
//   bus        : queue heads / pop strobes, output slot, grant status
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output_port_arbiter_if.master  bus
);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  arb_state_t       state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, grant_id_q, pick_idx, ptr_inc;
  logic [BC_W-1:0]  burst_cnt;
  logic             pick_found, grant_valid_q, out_valid_q;
  flit_t            out_data_q;
  logic             gnt_req, slot_free, at_limit, release_g, take;

  output_port_arbiter_rr_pick #(.N(PORTS), .W(PTR_W)) u_pick (
    .req   (bus.req_valid),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign gnt_req   = bus.req_valid[grant_id_q];
  assign slot_free = ~out_valid_q | bus.out_ready;
  assign at_limit  = (burst_cnt == BC_W'(MAX_BURST));
  // Pointer wraps at PORTS, not at 2^PTR_W.
  assign ptr_inc   = (grant_id_q == PTR_W'(PORTS - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_nxt = state;
    release_g = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE:  if (pick_found) state_nxt = GRANT;
      GRANT: begin
        // Release wins over take, so an empty grantee is never popped.
        if (!gnt_req || at_limit) begin
          release_g = 1'b1;
          state_nxt = IDLE;
        end else begin
          take = slot_free;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pop strobe is gated by rst_n so nothing is popped while held in reset.
  for (genvar p = 0; p < PORTS; p++) begin : g_take
    assign bus.req_take[p] = rst_n & take & (grant_id_q == PTR_W'(p));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      burst_cnt     <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_found) begin
        grant_id_q    <= pick_idx;
        grant_valid_q <= 1'b1;
        burst_cnt     <= '0;
      end
      if (release_g) begin
        grant_id_q    <= '0;
        grant_valid_q <= 1'b0;
        rr_ptr        <= ptr_inc;
      end
      if (take) begin
        out_data_q  <= bus.req_data[grant_id_q];
        out_valid_q <= 1'b1;
        burst_cnt   <= burst_cnt + 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter with a simple queue model.
module tb_output_port_arbiter;
  import output_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  output_port_arbiter_if bus();

  output_port_arbiter #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] fq [PORTS][$];
  logic [7:0] acc_q [$];
  int         glog [$];
  logic       gv_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int p = 0; p < PORTS; p++) begin
      bus.req_valid[p] = (fq[p].size() != 0);
      bus.req_data[p]  = (fq[p].size() != 0) ? fq[p][0] : 8'h00;
    end
  endtask

  task automatic load(input int p, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fq[p].push_back(base + 8'(i));
    refresh();
    #1;
  endtask

  // One clock: sample strobes before the edge, pop after it, then settle.
  task automatic step();
    logic [PORTS-1:0] tk;
    tk = bus.req_take;
    if (bus.out_valid && bus.out_ready) acc_q.push_back(bus.out_data);
    @(posedge clk);
    #1;
    for (int p = 0; p < PORTS; p++)
      if (tk[p] && fq[p].size() != 0) void'(fq[p].pop_front());
    refresh();
    #1;
    if (bus.grant_valid && !gv_prev) glog.push_back(int'(bus.grant_id));
    gv_prev = bus.grant_valid;
  endtask

  task automatic drain(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (acc_q.size() < n && c < budget) begin
      step();
      c++;
    end
    chk(tag, acc_q.size(), n);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    for (int p = 0; p < PORTS; p++) fq[p].delete();
    refresh();
    acc_q.delete();
    glog.delete();
    gv_prev = 1'b0;
    step();
    step();
    #3 rst_n = 1'b1;
    #1;
  endtask

  logic [7:0] exp_burst [12] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h90, 8'h91,
                                 8'h92, 8'h93, 8'h84, 8'h85, 8'h94, 8'h95};
  int exp_all [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    #2;
    // reset state
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_grant_valid", bus.grant_valid, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_req_take", bus.req_take, 0);
    step();
    #3 rst_n = 1'b1;
    #1;

    // single requester, cycle-exact latency
    load(0, 8'h80, 3);
    step();
    chk("single_grant_valid", bus.grant_valid, 1);
    chk("single_grant_id", bus.grant_id, 0);
    chk("single_no_flit_yet", bus.out_valid, 0);
    step();
    chk("single_f0", bus.out_data, 8'h80);
    chk("single_f0_valid", bus.out_valid, 1);
    step();
    chk("single_f1", bus.out_data, 8'h81);
    step();
    chk("single_f2", bus.out_data, 8'h82);
    step();
    chk("single_release", bus.grant_valid, 0);
    chk("single_out_empty", bus.out_valid, 0);
    chk("single_rr_ptr", dut.rr_ptr, 1);

    // burst limit with two competing queues
    do_reset();
    load(0, 8'h80, 6);
    load(1, 8'h90, 6);
    drain("burst_count", 12, 60);
    for (int i = 0; i < 12; i++) chk($sformatf("burst_flit%0d", i), acc_q[i], exp_burst[i]);
    chk("burst_grants", glog.size(), 4);
    chk("burst_g0", glog[0], 0);
    chk("burst_g1", glog[1], 1);
    chk("burst_g2", glog[2], 0);
    chk("burst_g3", glog[3], 1);

    // backpressure during a burst from queue 2
    do_reset();
    load(2, 8'hA0, 4);
    begin
      int c;
      c = 0;
      while (!(bus.out_valid && bus.out_data == 8'hA1) && c < 20) begin
        step();
        c++;
      end
      chk("bp_reach_a1", bus.out_data, 8'hA1);
    end
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_take%0d", i), bus.req_take, 0);
      step();
      chk($sformatf("bp_data%0d", i), bus.out_data, 8'hA1);
      chk($sformatf("bp_valid%0d", i), bus.out_valid, 1);
      chk($sformatf("bp_grant%0d", i), bus.grant_valid, 1);
    end
    bus.out_ready = 1'b1;
    #1;
    step();
    chk("bp_resume", bus.out_data, 8'hA2);
    drain("bp_count", 4, 20);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_flit%0d", i), acc_q[i], 8'hA0 + 8'(i));

    // wrap-around: pointer 4 after serving queue 3
    do_reset();
    load(3, 8'hC0, 1);
    drain("wrap_first", 1, 20);
    step();
    step();
    chk("wrap_rr_ptr", dut.rr_ptr, 4);
    load(0, 8'hD0, 1);
    load(4, 8'hE0, 1);
    drain("wrap_count", 3, 30);
    chk("wrap_g1", glog[1], 4);
    chk("wrap_g2", glog[2], 0);
    chk("wrap_d1", acc_q[1], 8'hE0);
    chk("wrap_d2", acc_q[2], 8'hD0);

    // all queues requesting
    do_reset();
    for (int p = 0; p < PORTS; p++) load(p, 8'(8'h10 * (p + 1)), 5);
    drain("all_count", 25, 200);
    chk("all_grants", glog.size(), 10);
    for (int i = 0; i < 6; i++) chk($sformatf("all_g%0d", i), glog[i], exp_all[i]);

    // asynchronous reset mid-burst
    do_reset();
    load(1, 8'hB0, 4);
    load(3, 8'hF0, 2);
    begin
      int c;
      c = 0;
      while (!(bus.out_valid && bus.out_data == 8'hB1) && c < 20) begin
        step();
        c++;
      end
      chk("mid_reach_b1", bus.out_data, 8'hB1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", bus.out_valid, 0);
    chk("mid_out_data", bus.out_data, 0);
    chk("mid_grant_valid", bus.grant_valid, 0);
    chk("mid_req_take", bus.req_take, 0);
    step();
    chk("mid_hold_take", bus.req_take, 0);
    chk("mid_hold_grant", bus.grant_valid, 0);
    #3 rst_n = 1'b1;
    #1;
    step();
    chk("mid_regrant_valid", bus.grant_valid, 1);
    chk("mid_regrant_id", bus.grant_id, 1);
    step();
    chk("mid_next_flit", bus.out_data, 8'hB2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
